// File: rtl/writeback_pkg.sv
// Shared ARM constants and types for the writeback stage.
package writeback_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned RNUM_W  = 4;

  localparam logic [XLEN-1:0]   CPSR_RESET = 32'h0000_00D3;
  localparam logic [RNUM_W-1:0] PC_REG     = 4'd15;

  typedef enum logic {
    RUN    = 1'b0,
    SHADOW = 1'b1
  } wb_state_t;

  typedef struct packed {
    logic              we;
    logic [RNUM_W-1:0] num;
    logic [XLEN-1:0]   data;
  } rf_write_t;

  // Branch targets are word aligned.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/wb_shadow.sv
// Squash window after a PC write: counts non-bubble slots before commits resume.
module wb_shadow
  import writeback_pkg::*;
#(
  parameter int unsigned SHADOW_DEPTH = 3
) (
  input  logic      clk,
  input  logic      Nrst,
  input  logic      inbubble,
  input  logic      pc_write,
  output wb_state_t state
);

  localparam int unsigned CW = (SHADOW_DEPTH > 0) ? $clog2(SHADOW_DEPTH + 1) : 1;

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (Nrst) begin
      state <= RUN;
      count <= '0;
    end else begin
      case (state)
        RUN: begin
          if (pc_write && (SHADOW_DEPTH != 0)) begin
            state <= SHADOW;
            count <= CW'(SHADOW_DEPTH);
          end
        end
        SHADOW: begin
          // Bubbles carry no instruction, so they do not shorten the window.
          if (!inbubble) begin
            count <= count - CW'(1);
            if (count == CW'(1)) begin
              state <= RUN;
            end
          end
        end
        default: begin
          state <= RUN;
          count <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/writeback.sv
// Writeback stage: commits register writes, redirects fetch on PC writes, tracks status and retire count.
module writeback
  import writeback_pkg::*;
#(
  parameter int unsigned SHADOW_DEPTH = 3
) (
  input  logic              clk,
  input  logic              Nrst,
  input  logic              inbubble,
  input  logic [XLEN-1:0]   pc,
  input  logic [XLEN-1:0]   insn,
  input  logic              write_reg,
  input  logic [RNUM_W-1:0] write_num,
  input  logic [XLEN-1:0]   write_data,
  input  logic [XLEN-1:0]   cpsr,
  input  logic [XLEN-1:0]   spsr,
  output logic              rf_we,
  output logic [RNUM_W-1:0] rf_wnum,
  output logic [XLEN-1:0]   rf_wdata,
  output logic [XLEN-1:0]   out_cpsr,
  output logic [XLEN-1:0]   out_spsr,
  output logic              jmp,
  output logic [XLEN-1:0]   jmppc,
  output logic              fwd_valid,
  output logic [RNUM_W-1:0] fwd_num,
  output logic [XLEN-1:0]   fwd_data,
  output logic [XLEN-1:0]   retired
);

  wb_state_t state;
  logic      valid_c;
  logic      pc_write_c;
  logic      reg_write_c;
  logic      unused_inputs;

  // pc/insn travel with the slot for debug visibility only.
  assign unused_inputs = ^{pc, insn};

  assign valid_c     = !inbubble && (state == RUN);
  assign pc_write_c  = valid_c && write_reg && (write_num == PC_REG);
  assign reg_write_c = valid_c && write_reg && (write_num != PC_REG);

  wb_shadow #(
    .SHADOW_DEPTH (SHADOW_DEPTH)
  ) u_shadow (
    .clk      (clk),
    .Nrst     (Nrst),
    .inbubble (inbubble),
    .pc_write (pc_write_c),
    .state    (state)
  );

  always_ff @(posedge clk) begin
    if (Nrst) begin
      rf_we    <= 1'b0;
      rf_wnum  <= '0;
      rf_wdata <= '0;
      jmp      <= 1'b0;
      jmppc    <= '0;
      retired  <= '0;
      out_cpsr <= CPSR_RESET;
      out_spsr <= '0;
    end else begin
      rf_we <= reg_write_c;
      jmp   <= pc_write_c;
      if (reg_write_c) begin
        rf_wnum  <= write_num;
        rf_wdata <= write_data;
      end
      if (pc_write_c) begin
        jmppc <= align_pc(write_data);
      end
      if (valid_c) begin
        retired  <= retired + XLEN'(1);
        out_cpsr <= cpsr;
        out_spsr <= spsr;
      end
    end
  end

  // Bypass exposes the value being written to the regfile this cycle.
  assign fwd_valid = rf_we;
  assign fwd_num   = rf_wnum;
  assign fwd_data  = rf_wdata;

endmodule

// File: tb/tb_writeback.sv
// Scoreboard bench for writeback: reference model pushes expectations, post-edge monitor pops and compares.
module tb_writeback;

  localparam int unsigned DEPTH = 3;

  logic        clk = 1'b0;
  logic        Nrst;
  logic        inbubble;
  logic [31:0] pc;
  logic [31:0] insn;
  logic        write_reg;
  logic [3:0]  write_num;
  logic [31:0] write_data;
  logic [31:0] cpsr;
  logic [31:0] spsr;
  logic        rf_we;
  logic [3:0]  rf_wnum;
  logic [31:0] rf_wdata;
  logic [31:0] out_cpsr;
  logic [31:0] out_spsr;
  logic        jmp;
  logic [31:0] jmppc;
  logic        fwd_valid;
  logic [3:0]  fwd_num;
  logic [31:0] fwd_data;
  logic [31:0] retired;

  writeback #(.SHADOW_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .Nrst       (Nrst),
    .inbubble   (inbubble),
    .pc         (pc),
    .insn       (insn),
    .write_reg  (write_reg),
    .write_num  (write_num),
    .write_data (write_data),
    .cpsr       (cpsr),
    .spsr       (spsr),
    .rf_we      (rf_we),
    .rf_wnum    (rf_wnum),
    .rf_wdata   (rf_wdata),
    .out_cpsr   (out_cpsr),
    .out_spsr   (out_spsr),
    .jmp        (jmp),
    .jmppc      (jmppc),
    .fwd_valid  (fwd_valid),
    .fwd_num    (fwd_num),
    .fwd_data   (fwd_data),
    .retired    (retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rf_we;
    logic [3:0]  wnum;
    logic [31:0] wdata;
    logic        jmp;
    logic [31:0] jmppc;
    logic [31:0] ret;
    logic [31:0] cpsr;
    logic [31:0] spsr;
  } exp_t;

  exp_t sb[$];
  exp_t m;
  int   m_cnt;
  int   checks;
  int   failures;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, want, $time);
    end
  endtask

  // Reference model: shadow tracked purely as a remaining-squash count.
  task automatic model(input logic rst, input logic bub, input logic wr,
                       input logic [3:0] num, input logic [31:0] data,
                       input logic [31:0] c, input logic [31:0] s);
    if (rst) begin
      m_cnt = 0;
      m = '{rf_we: 1'b0, wnum: 4'd0, wdata: 32'd0, jmp: 1'b0, jmppc: 32'd0,
            ret: 32'd0, cpsr: 32'h0000_00D3, spsr: 32'd0};
    end else begin
      m.rf_we = 1'b0;
      m.jmp   = 1'b0;
      if (!bub && m_cnt == 0) begin
        m.ret  = m.ret + 32'd1;
        m.cpsr = c;
        m.spsr = s;
        if (wr && num == 4'd15) begin
          m.jmp   = 1'b1;
          m.jmppc = data & 32'hFFFF_FFFC;
          m_cnt   = DEPTH;
        end else if (wr) begin
          m.rf_we = 1'b1;
          m.wnum  = num;
          m.wdata = data;
        end
      end else if (!bub && m_cnt > 0) begin
        m_cnt = m_cnt - 1;
      end
    end
  endtask

  task automatic step(input string tag, input logic rst, input logic bub, input logic wr,
                      input logic [3:0] num, input logic [31:0] data,
                      input logic [31:0] c, input logic [31:0] s);
    exp_t e;
    Nrst       = rst;
    inbubble   = bub;
    write_reg  = wr;
    write_num  = num;
    write_data = data;
    cpsr       = c;
    spsr       = s;
    pc         = pc + 32'd4;
    insn       = $urandom;
    model(rst, bub, wr, num, data, c, s);
    sb.push_back(m);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: scoreboard empty at %0t", tag, $time);
    end else begin
      e = sb.pop_front();
      check_eq({tag, ".rf_we"},     32'(rf_we),     32'(e.rf_we));
      check_eq({tag, ".rf_wnum"},   32'(rf_wnum),   32'(e.wnum));
      check_eq({tag, ".rf_wdata"},  rf_wdata,       e.wdata);
      check_eq({tag, ".jmp"},       32'(jmp),       32'(e.jmp));
      check_eq({tag, ".jmppc"},     jmppc,          e.jmppc);
      check_eq({tag, ".retired"},   retired,        e.ret);
      check_eq({tag, ".out_cpsr"},  out_cpsr,       e.cpsr);
      check_eq({tag, ".out_spsr"},  out_spsr,       e.spsr);
      check_eq({tag, ".fwd_valid"}, 32'(fwd_valid), 32'(e.rf_we));
      check_eq({tag, ".fwd_num"},   32'(fwd_num),   32'(e.wnum));
      check_eq({tag, ".fwd_data"},  fwd_data,       e.wdata);
    end
  endtask

  task automatic insn_slot(input string tag);
    step(tag, 1'b0, 1'b0, 1'b1, 4'd1, 32'hAAAA_0000 + 32'($urandom_range(0, 255)), 32'h1F, 32'h10);
  endtask

  task automatic bubble_slot(input string tag);
    step(tag, 1'b0, 1'b1, 1'b1, 4'd2, 32'hDEAD_BEEF, 32'h10, 32'h11);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    m_cnt    = 0;
    pc       = 32'h0000_1000;

    // Reset cycle carries a valid-looking write that must be discarded.
    step("reset", 1'b1, 1'b0, 1'b1, 4'd3, 32'hFFFF_FFFF, 32'h1F, 32'h1F);
    step("reset2", 1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 32'd0);

    step("bubble_cpsr", 1'b0, 1'b1, 1'b1, 4'd5, 32'h5555_5555, 32'h10, 32'h20);
    step("write_r3", 1'b0, 1'b0, 1'b1, 4'd3, 32'h1234_5678, 32'hD3, 32'h0);
    step("nowrite", 1'b0, 1'b0, 1'b0, 4'd7, 32'h0BAD_0BAD, 32'h13, 32'h0);
    step("nowrite_r15", 1'b0, 1'b0, 1'b0, 4'd15, 32'h0000_2000, 32'h13, 32'h0);

    // PC write then three squashed non-bubble slots, fourth commits.
    step("pcw", 1'b0, 1'b0, 1'b1, 4'd15, 32'h0000_1007, 32'h1F, 32'h0);
    insn_slot("sq1");
    insn_slot("sq2");
    insn_slot("sq3");
    insn_slot("post_shadow");

    // Bubbles interleaved inside the shadow must not shorten it.
    step("pcw2", 1'b0, 1'b0, 1'b1, 4'd15, 32'h0000_3ABE, 32'h1F, 32'h0);
    bubble_slot("sh_b1");
    insn_slot("sh_i1");
    bubble_slot("sh_b2");
    insn_slot("sh_i2");
    insn_slot("sh_i3");
    step("post_shadow2", 1'b0, 1'b0, 1'b1, 4'd9, 32'h9999_0009, 32'h1F, 32'h0);

    // Back-to-back PC write right after shadow exit.
    step("pcw3", 1'b0, 1'b0, 1'b1, 4'd15, 32'h0000_4002, 32'h1F, 32'h0);
    insn_slot("sh3_i1");
    step("reset_mid_shadow", 1'b1, 1'b0, 1'b1, 4'd4, 32'h4444_4444, 32'h1F, 32'h0);
    step("after_reset", 1'b0, 1'b0, 1'b1, 4'd4, 32'h0404_0404, 32'h1F, 32'h0);

    // Preload retired to its top value, then one valid slot must wrap it.
    force dut.retired = 32'hFFFF_FFFF;
    #1;
    release dut.retired;
    m.ret = 32'hFFFF_FFFF;
    step("retire_wrap", 1'b0, 1'b0, 1'b1, 4'd6, 32'h0606_0606, 32'h1F, 32'h0);
    step("retire_wrap2", 1'b0, 1'b0, 1'b0, 4'd6, 32'h0, 32'h1F, 32'h0);

    for (int i = 0; i < 200; i++) begin
      logic        r;
      logic        b;
      logic        w;
      logic [3:0]  n;
      r = ($urandom_range(0, 39) == 0);
      b = ($urandom_range(0, 3) == 0);
      w = ($urandom_range(0, 3) != 0);
      n = ($urandom_range(0, 5) == 0) ? 4'd15 : 4'($urandom_range(0, 14));
      step("rand", r, b, w, n, $urandom, $urandom, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
